// File: rtl/accel_pkg.sv
// Shared types for the systolic tile scheduler: FSM state encoding and the
// default width of tile/row counts.
// Contents: sched_state_t, SCHED_CNT_W.
package accel_pkg;

  localparam int SCHED_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LD_W  = 3'd1,
    LD_A  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } sched_state_t;

endpackage

// File: rtl/sched_counter.sv
// Up-counter with clear, load and enable, plus an equality terminal-count flag.
// Latency: count updates on the edge after clr/load/en; tc_o is combinational.
// Backpressure: none; the owner decides when to advance via en_i.
// Ports: clk_i/rst_i (sync active-high), clr_i > load_i > en_i priority,
//        load_val_i, term_i (compare value), cnt_o, tc_o (cnt_o == term_i).
module sched_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_cnt <= '0;
    end else if (load_i) begin
      r_cnt <= load_val_i;
    end else if (en_i) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt_o = r_cnt;
  assign tc_o  = (r_cnt == term_i);

endmodule

// File: rtl/systolic_tile_sched.sv
// Tile scheduler: per tile, grants R_g weight-row pushes, then M activation-row
// pushes, then idles 2*R_g-1 drain cycles; repeats for N tiles, then pulses done.
// Latency: grant one cycle after command handshake; R_g+M+2*R_g-1 cycles/tile.
// Backpressure: progress waits on w_push_i/a_push_i; cmd_ready_o low while busy.
// Ports: cmd_* command handshake, w/a_grant_o buffer grants, w/a_push_i buffer
//        pushes, busy_o, tile_idx_o, done_o pulse, err_o sticky protocol error.
// Optional macro SCHED_PERF_CNT_EN adds stall_cnt_o (granted cycles with no push).
module systolic_tile_sched
  import accel_pkg::*;
#(
  parameter int R_g     = 8,
  parameter int CNT_W_g = SCHED_CNT_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [CNT_W_g-1:0] cmd_tiles_i,
  input  logic [CNT_W_g-1:0] cmd_rows_i,
  output logic               w_grant_o,
  output logic               a_grant_o,
  input  logic               w_push_i,
  input  logic               a_push_i,
  output logic               busy_o,
  output logic [CNT_W_g-1:0] tile_idx_o,
  output logic               done_o,
  output logic               err_o
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt_o
`endif
);

  localparam int DRAIN_CYCLES = 2 * R_g - 1;
  localparam logic [CNT_W_g-1:0] W_TERM     = CNT_W_g'(R_g - 1);
  localparam logic [CNT_W_g-1:0] DRAIN_TERM = CNT_W_g'(DRAIN_CYCLES - 1);

  sched_state_t r_state, w_state_nxt;
  logic [CNT_W_g-1:0] r_tiles, r_rows;
  logic               r_err;

  logic               w_hs, w_w_ok, w_a_ok;
  logic               w_row_tc, w_drain_tc, w_tile_tc;
  logic [CNT_W_g-1:0] w_row_term;
  logic [CNT_W_g-1:0] w_row_cnt_unused, w_drain_cnt_unused;

  assign w_hs   = cmd_valid_i && (r_state == IDLE);
  assign w_w_ok = (r_state == LD_W) && w_push_i;
  assign w_a_ok = (r_state == LD_A) && a_push_i;

  // One row counter serves both load phases; it is cleared on each phase exit.
  assign w_row_term = (r_state == LD_W) ? W_TERM : (r_rows - 1'b1);

  sched_counter #(.W(CNT_W_g)) u_row_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (w_hs || ((w_w_ok || w_a_ok) && w_row_tc)),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (w_w_ok || w_a_ok),
    .term_i     (w_row_term),
    .cnt_o      (w_row_cnt_unused),
    .tc_o       (w_row_tc)
  );

  sched_counter #(.W(CNT_W_g)) u_drain_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (w_hs || ((r_state == DRAIN) && w_drain_tc)),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (r_state == DRAIN),
    .term_i     (DRAIN_TERM),
    .cnt_o      (w_drain_cnt_unused),
    .tc_o       (w_drain_tc)
  );

  // Last tile is tile_idx == N-1; only reached with N >= 1.
  sched_counter #(.W(CNT_W_g)) u_tile_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (w_hs),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       ((r_state == DRAIN) && w_drain_tc && !w_tile_tc),
    .term_i     (r_tiles - 1'b1),
    .cnt_o      (tile_idx_o),
    .tc_o       (w_tile_tc)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_tiles <= '0;
      r_rows  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hs) begin
        r_tiles <= cmd_tiles_i;
        r_rows  <= cmd_rows_i;
        r_err   <= 1'b0;
      end else if ((w_push_i && (r_state != LD_W)) || (a_push_i && (r_state != LD_A))) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (cmd_valid_i) begin
          w_state_nxt = ((cmd_tiles_i == '0) || (cmd_rows_i == '0)) ? DONE : LD_W;
        end
      end
      LD_W:  if (w_w_ok && w_row_tc) w_state_nxt = LD_A;
      LD_A:  if (w_a_ok && w_row_tc) w_state_nxt = DRAIN;
      DRAIN: if (w_drain_tc) w_state_nxt = w_tile_tc ? DONE : LD_W;
      DONE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign cmd_ready_o = (r_state == IDLE);
  assign busy_o      = (r_state != IDLE);
  assign w_grant_o   = (r_state == LD_W);
  assign a_grant_o   = (r_state == LD_A);
  assign done_o      = (r_state == DONE);
  assign err_o       = r_err;

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || w_hs) begin
      r_stall_cnt <= '0;
    end else if ((((r_state == LD_W) && !w_push_i) || ((r_state == LD_A) && !a_push_i))
                 && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: doc/systolic_tile_sched.md
# systolic_tile_sched

Tile scheduler for the systolic accelerator. Sequences one command of N weight tiles: it loads R_g weight rows, then streams M activation rows, then drains the array, and repeats per tile. It owns the stall/grant lines of the weight buffer and the activation double buffer, so only one buffer pushes at a time. It sits between the DMA/host command path and the two buffer slaves feeding the systolic array.

## Interface
Parameters:
- R_g, 8, systolic array rows (= weight rows per tile)
- CNT_W_g, 16, width of tile/row counts

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i
- cmd_tiles_i  in  CNT_W_g  number of tiles N
- cmd_rows_i  in  CNT_W_g  activation rows per tile M
- w_grant_o  out  1  weight buffer may push (drives its stall_i = !w_grant_o)
- a_grant_o  out  1  activation buffer may push (stall_i = !a_grant_o)
- w_push_i  in  1  weight buffer pushing_o
- a_push_i  in  1  activation buffer pushing_o
- busy_o  out  1  command in progress
- tile_idx_o  out  CNT_W_g  current tile index
- done_o  out  1  one-cycle pulse at command completion
- err_o  out  1  sticky protocol error; cleared only by rst_i or by a command handshake
- stall_cnt_o  out  32  perf counter, present only with the macro

## Operation
- States: IDLE, LD_W, LD_A, DRAIN, DONE (Moore outputs).
- IDLE: cmd_ready_o=1. A handshake latches N and M, clears err_o and tile_idx_o.
  - N==0 or M==0: go to DONE directly.
  - Otherwise go to LD_W.
- LD_W: w_grant_o=1. Count w_push_i. The R_g-th push moves the FSM to LD_A and clears the row counter.
- LD_A: a_grant_o=1. Count a_push_i. The M-th push moves the FSM to DRAIN.
- DRAIN: no grants. Count exactly DRAIN_CYCLES = 2*R_g-1 cycles (R_g-1 skew plus R_g array depth).
  - Then, if tile_idx_o+1 < N: increment tile_idx_o and go to LD_W.
  - Else go to DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- busy_o=1 in every state except IDLE.
- w_grant_o and a_grant_o are never high together.
- Pushes that arrive without their grant are not counted and set err_o. The state is unchanged.
- Counters are CNT_W_g wide and compare with equality. No wrap-around is possible, because N and M are bounded by CNT_W_g.

## Timing
- Reset values: state IDLE, cmd_ready_o=1, all other outputs 0, counters 0.
- Reset mid-operation returns to IDLE on the same edge. Grants are low from the next cycle and no done_o is produced.
- Handshake at edge t: the grant is high in cycle t+1.
- Last required push sampled at edge t: the old grant is low and the next grant (or DRAIN) is active from t+1. No bubble and no overlap.
- Per-tile latency with back-to-back pushes: R_g + M + DRAIN_CYCLES cycles.
- A command with N=M=0: done_o is high in the cycle after the handshake.
- cmd_valid_i while busy is ignored (cmd_ready_o=0).
- A push on the same cycle as a state exit is counted by the exiting state only.

## Configuration
- SCHED_PERF_CNT_EN defined:
  - stall_cnt_o exists.
  - It counts cycles in LD_W/LD_A where the granted push input is low.
  - It clears on handshake and saturates at 2^32-1.
- Undefined: the port and the counter are absent, and behaviour is otherwise identical.

## Structure
- accel_pkg: sched_state_t enum (IDLE, LD_W, LD_A, DRAIN, DONE) and the default count width constant.
- DRAIN_CYCLES is a localparam in the module, derived from R_g.
- One sub-module: sched_counter (load/clear/enable up-counter with terminal-count compare). It is instantiated for the row count, the drain count and the tile count.

## Test plan
- R_g=8, N=2, M=4, pushes every cycle:
  - w_grant_o high 8 cycles, then a_grant_o high 4 cycles, then 15 idle drain cycles, per tile.
  - tile_idx_o goes 0 then 1.
  - done_o pulses once, 55 cycles after the handshake.
- N=0, M=5: done_o in the cycle after the handshake, grants never high.
- a_push_i pulsed during LD_W: err_o=1, weight count unaffected, sequence completes normally.
- rst_i asserted mid-LD_A of tile 1:
  - Next cycle IDLE, grants 0, tile_idx_o=0, no done_o.
  - A new command then runs normally.
- Random gaps on w_push_i/a_push_i with N=3, M=7:
  - Never both grants high.
  - With SCHED_PERF_CNT_EN, stall_cnt_o equals the number of gap cycles.
- cmd_valid_i held high during a command: no second acceptance until after done_o.
